payload_fifo: RTL and testbench

PAYLOAD_FIFO -- requirements
Module: payload_fifo

---
 rtl/nic_pkg.sv | 22 ++
 rtl/payload_fifo_mem.sv | 28 ++
 rtl/payload_fifo.sv | 131 +++++++++++++
 tb/tb_payload_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// Shared NIC definitions: payload FIFO geometry, entry layout and counter width.
package nic_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;
  localparam int BYTE_W     = 8;
  localparam int ENTRY_W    = 9;
  localparam int PKT_CNT_W  = 16;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

  function automatic fifo_entry_t make_entry(input logic last, input logic [BYTE_W-1:0] data);
    fifo_entry_t e;
    e.last = last;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/payload_fifo_mem.sv
// Payload FIFO storage: one synchronous write port, one asynchronous read port.
// The array is never reset; stale contents are masked by the level counter.
module payload_fifo_mem
  import nic_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_entry
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Storage write on the rising edge.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = mem_q[rd_addr];

endmodule

// File: rtl/payload_fifo.sv
// Payload byte FIFO: a one-byte hold stage marks the final byte of each packet
// (in_valid falling edge) before committing {last, data} into show-ahead storage.
module payload_fifo
  import nic_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic [BYTE_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW:0]          level,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic                 overflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic                 hold_valid_q, hold_valid_d;
  logic [BYTE_W-1:0]    hold_data_q,  hold_data_d;
  logic [AW-1:0]        wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q,     rd_ptr_d;
  logic [AW:0]          level_q,      level_d;
  logic [PKT_CNT_W-1:0] pkt_count_q,  pkt_count_d;
  logic                 overflow_q,   overflow_d;

  logic               commit_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_en_s;
  logic               drop_s;
  fifo_entry_t        wr_entry_s;
  logic [ENTRY_W-1:0] rd_entry_s;
  fifo_entry_t        head_s;

  assign commit_s   = hold_valid_q;
  assign full_s     = (level_q == FULL_LEVEL);
  assign out_valid  = (level_q != {(AW+1){1'b0}});
  assign pop_s      = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en_s    = commit_s & (~full_s | pop_s);
  assign drop_s     = commit_s & full_s & ~pop_s;
  assign wr_entry_s = make_entry(~in_valid, hold_data_q);

  payload_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock    (clock),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_ptr_q),
    .wr_entry (wr_entry_s),
    .rd_addr  (rd_ptr_q),
    .rd_entry (rd_entry_s)
  );

  assign head_s    = rd_entry_s;
  assign out_data  = head_s.data;
  assign out_last  = out_valid & head_s.last;
  assign level     = level_q;
  assign pkt_count = pkt_count_q;
  assign overflow  = overflow_q;

  // Next-state for hold stage, pointers, level and status counters.
  always_comb begin
    hold_valid_d = in_valid;
    hold_data_d  = hold_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    pkt_count_d  = pkt_count_q;
    overflow_d   = overflow_q | drop_s;

    if (in_valid) begin
      hold_data_d = in_data;
    end else begin
      hold_data_d = hold_data_q;
    end

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    if (pop_s && out_last) begin
      pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= {BYTE_W{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      level_q      <= {(AW+1){1'b0}};
      pkt_count_q  <= {PKT_CNT_W{1'b0}};
      overflow_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pkt_count_q  <= pkt_count_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_payload_fifo.sv
// Randomized and directed bench for payload_fifo against a queue-based packet model.
module tb_payload_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;
  logic [15:0]   pkt_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [8:0]  m_q[$];
  logic        m_hold_v;
  logic [7:0]  m_hold_d;
  logic [15:0] m_pkt;
  logic        m_ovf;
  logic [8:0]  dut_pops[$];

  payload_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .pkt_count (pkt_count),
    .overflow  (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge worth of packet-level behaviour.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    logic       pop;
    logic       was_full;
    logic [8:0] e;
    pop      = (m_q.size() > 0) && r;
    was_full = (m_q.size() == DEPTH);
    if (pop) begin
      e = m_q.pop_front();
      if (e[8]) m_pkt = m_pkt + 16'd1;
    end
    if (m_hold_v) begin
      if (was_full && !pop) m_ovf = 1'b1;
      else m_q.push_back({~v, m_hold_d});
    end
    m_hold_v = v;
    m_hold_d = d;
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, (m_q.size() > 0) ? 32'd1 : 32'd0);
    chk("level", level, m_q.size());
    if (m_q.size() > 0) begin
      chk("out_data", out_data, m_q[0][7:0]);
      chk("out_last", out_last, m_q[0][8]);
    end else begin
      chk("out_last_empty", out_last, 32'd0);
    end
    chk("pkt_count", pkt_count, m_pkt);
    chk("overflow", overflow, m_ovf);
  endtask

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    if (out_valid && out_ready) dut_pops.push_back({out_last, out_data});
    @(posedge clock);
    model_edge(v, d, r);
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_level", level, 32'd0);
    chk("rst_out_last", out_last, 32'd0);
    m_q.delete();
    dut_pops.delete();
    m_hold_v = 1'b0;
    m_hold_d = 8'h00;
    m_pkt    = 16'd0;
    m_ovf    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_pkt", pkt_count, 32'd0);
    chk("rst_ovf", overflow, 32'd0);
    compare_all();
  endtask

  task automatic check_pops(input string tag, input logic [8:0] exp[$]);
    chk({tag, "_count"}, dut_pops.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dut_pops.size()) chk(tag, dut_pops[i], exp[i]);
    end
  endtask

  initial begin
    logic [8:0] exp_q[$];
    int rprob;
    int vprob;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    m_hold_v = 1'b0; m_hold_d = 8'h00; m_pkt = 16'd0; m_ovf = 1'b0;
    @(negedge clock);

    // Three-byte packet, consumer always ready.
    do_reset();
    step(1'b1, 8'h11, 1'b1);
    chk("lat_k1", out_valid, 32'd0);
    step(1'b1, 8'h22, 1'b1);
    chk("lat_k2", out_valid, 32'd1);
    chk("lat_k2_data", out_data, 32'h11);
    step(1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    exp_q = '{9'h011, 9'h022, 9'h133};
    check_pops("pkt3_pops", exp_q);
    chk("pkt3_count", pkt_count, 32'd1);

    // Single-byte packet.
    do_reset();
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    chk("single_level", level, 32'd1);
    chk("single_data", out_data, 32'hA5);
    chk("single_last", out_last, 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("single_level_after", level, 32'd0);
    chk("single_pkt", pkt_count, 32'd1);

    // Overfill: 20-byte packet into 16 entries with no consumer.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_level", level, 32'd16);
    chk("ovf_flag", overflow, 32'd1);
    for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'(i)});
    check_pops("ovf_pops", exp_q);
    chk("ovf_pkt", pkt_count, 32'd0);

    // Full FIFO streaming through the pointer wrap.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
    chk("full_level", level, 32'd16);
    for (int i = 17; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk("stream_level", level, 32'd16);
    end
    chk("stream_ovf", overflow, 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back({(i == 39), 8'(i)});
    check_pops("stream_pops", exp_q);

    // Reset in the middle of a packet.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    do_reset();
    step(1'b1, 8'hDE, 1'b1);
    step(1'b1, 8'hAD, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    exp_q = '{9'h0DE, 9'h1AD};
    check_pops("midrst_pops", exp_q);

    // Back-to-back packets with one idle cycle.
    do_reset();
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    exp_q = '{9'h001, 9'h102, 9'h103};
    check_pops("b2b_pops", exp_q);
    chk("b2b_pkt", pkt_count, 32'd2);

    // Randomized traffic with varying consumer throughput.
    do_reset();
    rprob = 50;
    vprob = 70;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 200) == 0) begin
        rprob = $urandom_range(0, 100);
        vprob = $urandom_range(30, 95);
      end
      step(($urandom_range(0, 99) < vprob), 8'($urandom), ($urandom_range(0, 99) < rprob));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
